// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one core bus between instruction fetch (ibus) and
// the MEM stage (dbus). dbus wins contention unless ibus has been passed over
// STARVE_MAX times in a row. A flushed fetch still completes on the bus, but its
// response is swallowed.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    // fetch side
    input  logic                i_req_valid,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic                i_flush,
    output logic                i_resp_valid,
    output logic [31:0]         i_resp_data,
    // MEM-stage side
    input  logic                d_req_valid,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [2:0]          d_req_size,
    input  logic [DATA_W/8-1:0] d_req_strobe,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_data,
    // core bus
    output logic                bus_valid,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [2:0]          bus_size,
    output logic [DATA_W/8-1:0] bus_strobe,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ready,
    input  logic [DATA_W-1:0]   bus_data
);

    localparam int unsigned     CntW      = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e          state_q;
    logic            drop_q;
    logic [CntW-1:0] starve_q;

    logic            i_elig;
    logic            pick_i;
    logic            pick_d;
    logic [CntW-1:0] starve_inc;

    // Grant decision for the IDLE cycle; a flushed fetch is not eligible.
    always_comb begin
        i_elig     = i_req_valid && !i_flush;
        pick_d     = d_req_valid && !(i_elig && (starve_q == StarveMax));
        pick_i     = i_elig && !pick_d;
        starve_inc = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    end

    // Arbiter FSM with registered bus request outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            drop_q     <= 1'b0;
            starve_q   <= '0;
            bus_valid  <= 1'b0;
            bus_addr   <= '0;
            bus_size   <= 3'b000;
            bus_strobe <= '0;
            bus_wdata  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_d) begin
                        state_q    <= StBusyD;
                        bus_valid  <= 1'b1;
                        bus_addr   <= d_req_addr;
                        bus_size   <= d_req_size;
                        bus_strobe <= d_req_strobe;
                        bus_wdata  <= d_req_wdata;
                        // Only count passes over a fetch that is actually waiting.
                        starve_q   <= i_req_valid ? starve_inc : '0;
                    end else if (pick_i) begin
                        state_q    <= StBusyI;
                        bus_valid  <= 1'b1;
                        bus_addr   <= i_req_addr;
                        bus_size   <= 3'b010;
                        bus_strobe <= '0;
                        bus_wdata  <= '0;
                        starve_q   <= '0;
                        drop_q     <= 1'b0;
                    end else if (!i_req_valid) begin
                        starve_q   <= '0;
                    end
                end
                StBusyI: begin
                    if (bus_ready) begin
                        state_q   <= StIdle;
                        bus_valid <= 1'b0;
                        drop_q    <= 1'b0;
                    end else if (i_flush) begin
                        drop_q    <= 1'b1;
                    end
                end
                StBusyD: begin
                    if (bus_ready) begin
                        state_q   <= StIdle;
                        bus_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    bus_valid <= 1'b0;
                end
            endcase
        end
    end

    // Response pulses follow bus_ready directly; a flush on the ready cycle also drops.
    always_comb begin
        i_resp_valid = (state_q == StBusyI) && bus_ready && !drop_q && !i_flush;
        d_resp_valid = (state_q == StBusyD) && bus_ready;
        i_resp_data  = i_resp_valid ? bus_data[31:0] : 32'h0;
        d_resp_data  = d_resp_valid ? bus_data : '0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scenario tasks with a response scoreboard.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_req_valid;
    logic [63:0] i_req_addr;
    logic        i_flush;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic        d_req_valid;
    logic [63:0] d_req_addr;
    logic [2:0]  d_req_size;
    logic [7:0]  d_req_strobe;
    logic [63:0] d_req_wdata;
    logic        d_resp_valid;
    logic [63:0] d_resp_data;
    logic        bus_valid;
    logic [63:0] bus_addr;
    logic [2:0]  bus_size;
    logic [7:0]  bus_strobe;
    logic [63:0] bus_wdata;
    logic        bus_ready;
    logic [63:0] bus_data;

    int n_chk;
    int n_fail;

    logic [31:0] exp_i_q[$];
    logic [63:0] exp_d_q[$];

    mem_bus_arbiter #(
        .ADDR_W    (64),
        .DATA_W    (64),
        .STARVE_MAX(4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_req_valid (i_req_valid),
        .i_req_addr  (i_req_addr),
        .i_flush     (i_flush),
        .i_resp_valid(i_resp_valid),
        .i_resp_data (i_resp_data),
        .d_req_valid (d_req_valid),
        .d_req_addr  (d_req_addr),
        .d_req_size  (d_req_size),
        .d_req_strobe(d_req_strobe),
        .d_req_wdata (d_req_wdata),
        .d_resp_valid(d_resp_valid),
        .d_resp_data (d_resp_data),
        .bus_valid   (bus_valid),
        .bus_addr    (bus_addr),
        .bus_size    (bus_size),
        .bus_strobe  (bus_strobe),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_data    (bus_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; i_req_valid = 1'b1; d_req_valid = 1'b1; i_flush = 1'b0;
        i_req_addr = 64'h8000_0000; d_req_addr = 64'h2000; d_req_size = 3'b011;
        d_req_strobe = 8'h00; d_req_wdata = 64'h0; bus_ready = 1'b0; bus_data = 64'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid); end
            n_chk++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b expected 00", {i_resp_valid, d_resp_valid}); end
            step();
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0; resetn = 1'b1;
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_bus_valid: got %b expected 0", bus_valid); end
        n_chk++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0 (IDLE)", dut.state_q); end
        n_chk++; if (dut.starve_q !== 3'd0) begin n_fail++; $display("FAIL reset_starve: got %0d expected 0", dut.starve_q); end
        step();
    endtask

    task automatic test_lone_fetch();
        logic [31:0] e;
        i_req_valid = 1'b1; i_req_addr = 64'h8000_0000;
        exp_i_q.push_back(32'h0000_0013);
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_t0_bus_valid: got %b expected 0", bus_valid); end
        step();
        for (int t = 1; t <= 3; t++) begin
            if (t == 3) begin bus_ready = 1'b1; bus_data = 64'h0000_0000_0000_0013; end
            @(negedge clk);
            n_chk++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_bus_valid_t%0d: got %b expected 1", t, bus_valid); end
            n_chk++; if (bus_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL fetch_bus_addr: got %h expected 80000000", bus_addr); end
            n_chk++; if (bus_size !== 3'b010 || bus_strobe !== 8'h00) begin n_fail++; $display("FAIL fetch_size_strobe: got %b/%h expected 010/00", bus_size, bus_strobe); end
            if (t < 3) begin
                n_chk++; if (i_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_early_resp_t%0d: got %b expected 0", t, i_resp_valid); end
            end else begin
                n_chk++; if (i_resp_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_resp_valid: got %b expected 1", i_resp_valid); end
                else if (exp_i_q.size() == 0) begin n_fail++; $display("FAIL fetch_resp_sb: got %h expected nothing", i_resp_data); end
                else begin
                    e = exp_i_q.pop_front();
                    n_chk++; if (i_resp_data !== e) begin n_fail++; $display("FAIL fetch_resp_data: got %h expected %h", i_resp_data, e); end
                end
            end
            step();
        end
        bus_ready = 1'b0; i_req_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_after_bus_valid: got %b expected 0", bus_valid); end
        step();
        // Unsolicited bus_ready in IDLE must be ignored.
        bus_ready = 1'b1; bus_data = 64'hFFFF;
        @(negedge clk);
        n_chk++; if ({i_resp_valid, d_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL unsolicited_ready: got %b expected 00", {i_resp_valid, d_resp_valid}); end
        step();
        bus_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL unsolicited_bus_valid: got %b expected 0", bus_valid); end
        step();
    endtask

    task automatic test_contention();
        logic [31:0] ei;
        logic [63:0] ed;
        i_req_valid = 1'b1; i_req_addr = 64'h8000_0004;
        d_req_valid = 1'b1; d_req_addr = 64'h1000; d_req_size = 3'b011;
        d_req_strobe = 8'hFF; d_req_wdata = 64'hDEAD_BEEF;
        step();
        bus_ready = 1'b1; bus_data = 64'h55; exp_d_q.push_back(64'h55);
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b1 || bus_addr !== 64'h1000) begin n_fail++; $display("FAIL cont_dbus_first: got %b/%h expected 1/1000", bus_valid, bus_addr); end
        n_chk++; if (bus_strobe !== 8'hFF || bus_wdata !== 64'hDEAD_BEEF || bus_size !== 3'b011) begin n_fail++; $display("FAIL cont_store_fields: got %h/%h/%b expected ff/deadbeef/011", bus_strobe, bus_wdata, bus_size); end
        n_chk++; if (d_resp_valid !== 1'b1 || i_resp_valid !== 1'b0) begin n_fail++; $display("FAIL cont_d_resp: got d=%b i=%b expected d=1 i=0", d_resp_valid, i_resp_valid); end
        else if (exp_d_q.size() == 0) begin n_fail++; $display("FAIL cont_d_sb: got %h expected nothing", d_resp_data); end
        else begin
            ed = exp_d_q.pop_front();
            n_chk++; if (d_resp_data !== ed) begin n_fail++; $display("FAIL cont_d_data: got %h expected %h", d_resp_data, ed); end
        end
        step();
        d_req_valid = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL cont_turnaround: got %b expected 0", bus_valid); end
        step();
        bus_ready = 1'b1; bus_data = 64'hAAAA_BBBB_0000_0093; exp_i_q.push_back(32'h0000_0093);
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b1 || bus_addr !== 64'h8000_0004 || bus_size !== 3'b010) begin n_fail++; $display("FAIL cont_ibus_grant: got %b/%h/%b expected 1/80000004/010", bus_valid, bus_addr, bus_size); end
        n_chk++; if (i_resp_valid !== 1'b1) begin n_fail++; $display("FAIL cont_i_resp: got %b expected 1", i_resp_valid); end
        else if (exp_i_q.size() == 0) begin n_fail++; $display("FAIL cont_i_sb: got %h expected nothing", i_resp_data); end
        else begin
            ei = exp_i_q.pop_front();
            n_chk++; if (i_resp_data !== ei) begin n_fail++; $display("FAIL cont_i_data: got %h expected %h", i_resp_data, ei); end
        end
        step();
        i_req_valid = 1'b0; bus_ready = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        int          n_grant;
        int          n_d;
        bit          got_i;
        logic [31:0] ei;
        logic [63:0] ed;
        n_grant = 0; n_d = 0; got_i = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 64'h8000_0008;
        d_req_valid = 1'b1; d_req_addr = 64'h3000; d_req_size = 3'b011;
        d_req_strobe = 8'h00; d_req_wdata = 64'h0;
        for (int cyc = 0; cyc < 30 && !got_i; cyc++) begin
            if (bus_valid === 1'b1) begin
                bus_ready = 1'b1; bus_data = 64'h100 + 64'(cyc);
                // Model: four dbus grants, then the ibus grant.
                if (n_grant < 4) begin
                    exp_d_q.push_back(64'h100 + 64'(cyc));
                    n_chk++; if (bus_addr !== 64'h3000) begin n_fail++; $display("FAIL starve_grant%0d_addr: got %h expected 3000", n_grant, bus_addr); end
                end else begin
                    exp_i_q.push_back(32'h100 + 32'(cyc));
                    n_chk++; if (bus_addr !== 64'h8000_0008) begin n_fail++; $display("FAIL starve_ibus_addr: got %h expected 80000008", bus_addr); end
                    n_chk++; if (dut.starve_q !== 3'd0) begin n_fail++; $display("FAIL starve_cnt_clear: got %0d expected 0", dut.starve_q); end
                end
                n_grant++;
            end else begin
                bus_ready = 1'b0;
            end
            @(negedge clk);
            if (d_resp_valid === 1'b1) begin
                n_d++;
                if (exp_d_q.size() == 0) begin n_chk++; n_fail++; $display("FAIL starve_d_sb: got %h expected nothing", d_resp_data); end
                else begin
                    ed = exp_d_q.pop_front();
                    n_chk++; if (d_resp_data !== ed) begin n_fail++; $display("FAIL starve_d_data: got %h expected %h", d_resp_data, ed); end
                end
            end
            if (i_resp_valid === 1'b1) begin
                got_i = 1'b1;
                n_chk++; if (n_d != 4) begin n_fail++; $display("FAIL starve_d_count: got %0d expected 4", n_d); end
                if (exp_i_q.size() == 0) begin n_chk++; n_fail++; $display("FAIL starve_i_sb: got %h expected nothing", i_resp_data); end
                else begin
                    ei = exp_i_q.pop_front();
                    n_chk++; if (i_resp_data !== ei) begin n_fail++; $display("FAIL starve_i_data: got %h expected %h", i_resp_data, ei); end
                end
                i_req_valid = 1'b0; d_req_valid = 1'b0;
            end
            step();
        end
        n_chk++; if (!got_i) begin n_fail++; $display("FAIL starve_timeout: got no ibus response expected one within 30 cycles"); end
        i_req_valid = 1'b0; d_req_valid = 1'b0; bus_ready = 1'b0;
        // Drain any grant left behind by a misbehaving arbiter.
        for (int c = 0; c < 4; c++) begin
            bus_ready = bus_valid;
            step();
        end
        bus_ready = 1'b0;
        n_chk++; if (exp_d_q.size() != 0 || exp_i_q.size() != 0) begin n_fail++; $display("FAIL starve_sb_leftover: got %0d/%0d expected 0/0", exp_d_q.size(), exp_i_q.size()); end
        exp_d_q.delete(); exp_i_q.delete();
        step();
    endtask

    task automatic test_flush_in_flight();
        logic [31:0] ei;
        i_req_valid = 1'b1; i_req_addr = 64'h8000_0008;
        step();
        i_flush = 1'b1; i_req_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b1 || bus_addr !== 64'h8000_0008) begin n_fail++; $display("FAIL flush_grant: got %b/%h expected 1/80000008", bus_valid, bus_addr); end
        step();
        i_flush = 1'b0; i_req_valid = 1'b1; i_req_addr = 64'h8000_0010;
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b1 || bus_addr !== 64'h8000_0008) begin n_fail++; $display("FAIL flush_bus_stable: got %b/%h expected 1/80000008", bus_valid, bus_addr); end
        step();
        bus_ready = 1'b1; bus_data = 64'h77;
        @(negedge clk);
        n_chk++; if (i_resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b expected 0", i_resp_valid); end
        step();
        bus_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b expected 0", bus_valid); end
        step();
        bus_ready = 1'b1; bus_data = 64'h0000_0000_1234_5678; exp_i_q.push_back(32'h1234_5678);
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b1 || bus_addr !== 64'h8000_0010) begin n_fail++; $display("FAIL flush_new_fetch: got %b/%h expected 1/80000010", bus_valid, bus_addr); end
        n_chk++; if (i_resp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_new_resp: got %b expected 1", i_resp_valid); end
        else if (exp_i_q.size() == 0) begin n_fail++; $display("FAIL flush_new_sb: got %h expected nothing", i_resp_data); end
        else begin
            ei = exp_i_q.pop_front();
            n_chk++; if (i_resp_data !== ei) begin n_fail++; $display("FAIL flush_new_data: got %h expected %h", i_resp_data, ei); end
        end
        step();
        i_req_valid = 1'b0; bus_ready = 1'b0;
        step();
        exp_i_q.delete();
    endtask

    task automatic test_flush_edges();
        logic [31:0] ei;
        logic [63:0] ed;
        // Flush alongside the request in IDLE blocks the grant.
        i_req_valid = 1'b1; i_req_addr = 64'h8000_0020; i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_no_grant: got %b expected 0", bus_valid); end
        step();
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b1 || bus_addr !== 64'h8000_0020) begin n_fail++; $display("FAIL flush_late_grant: got %b/%h expected 1/80000020", bus_valid, bus_addr); end
        step();
        // Flush on the ready cycle suppresses the response.
        bus_ready = 1'b1; bus_data = 64'h99; i_flush = 1'b1;
        @(negedge clk);
        n_chk++; if (i_resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_at_ready: got %b expected 0", i_resp_valid); end
        step();
        bus_ready = 1'b0; i_flush = 1'b0; i_req_valid = 1'b0;
        step();
        // Next fetch is served normally.
        i_req_valid = 1'b1; i_req_addr = 64'h8000_0024;
        step();
        bus_ready = 1'b1; bus_data = 64'h0000_0000_0000_00B3; exp_i_q.push_back(32'h0000_00B3);
        @(negedge clk);
        n_chk++; if (i_resp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_recover_resp: got %b expected 1", i_resp_valid); end
        else if (exp_i_q.size() == 0) begin n_fail++; $display("FAIL flush_recover_sb: got %h expected nothing", i_resp_data); end
        else begin
            ei = exp_i_q.pop_front();
            n_chk++; if (i_resp_data !== ei) begin n_fail++; $display("FAIL flush_recover_data: got %h expected %h", i_resp_data, ei); end
        end
        step();
        i_req_valid = 1'b0; bus_ready = 1'b0;
        step();
        // Flush during a dbus transaction has no effect on it.
        d_req_valid = 1'b1; d_req_addr = 64'h4000; d_req_strobe = 8'h00;
        step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0; bus_ready = 1'b1; bus_data = 64'h1122_3344_5566_7788;
        exp_d_q.push_back(64'h1122_3344_5566_7788);
        @(negedge clk);
        n_chk++; if (d_resp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_dbus_resp: got %b expected 1", d_resp_valid); end
        else if (exp_d_q.size() == 0) begin n_fail++; $display("FAIL flush_dbus_sb: got %h expected nothing", d_resp_data); end
        else begin
            ed = exp_d_q.pop_front();
            n_chk++; if (d_resp_data !== ed) begin n_fail++; $display("FAIL flush_dbus_data: got %h expected %h", d_resp_data, ed); end
        end
        step();
        d_req_valid = 1'b0; bus_ready = 1'b0;
        step();
        exp_i_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_reset_mid();
        d_req_valid = 1'b1; d_req_addr = 64'h5000;
        step();
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: got %b expected 1", bus_valid); end
        d_req_valid = 1'b0; resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        n_chk++; if (bus_valid !== 1'b0 || bus_addr !== 64'h0) begin n_fail++; $display("FAIL rstmid_abandon: got %b/%h expected 0/0", bus_valid, bus_addr); end
        step();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_lone_fetch();
        test_contention();
        test_starvation();
        test_flush_in_flight();
        test_flush_edges();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
